// File: rtl/bcd7_pkg.sv
// bcd7_pkg: shared 7-segment definitions for the BCD display blocks.
// Segment vectors are ordered [0:6] = a..g, active-high.
package bcd7_pkg;

    localparam int SEG_W = 7;

    typedef logic [0:SEG_W-1] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_mux_display_if.sv
// bcd_mux_display_if: data-in / display-out bundle of the multiplexed
// BCD display driver. The master loads digits and watches the display;
// the slave is the driver itself.
interface bcd_mux_display_if
    import bcd7_pkg::*;
#(
    parameter int NDIG = 4
);

    logic              load;
    logic [4*NDIG-1:0] d;
    logic [NDIG-1:0]   dp;
    seg_t              seg;
    logic              dpo;
    logic [NDIG-1:0]   an;
    logic              frame;

    modport master (
        output load, d, dp,
        input  seg, dpo, an, frame
    );

    modport slave (
        input  load, d, dp,
        output seg, dpo, an, frame
    );

endinterface

// File: rtl/bcd_seg7.sv
// bcd_seg7: combinational BCD digit to 7-segment pattern.
// Codes 10..15 are not decimal digits and are shown blank.
module bcd_seg7
    import bcd7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    // Plain lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_mux_display.sv
// bcd_mux_display: time-multiplexed NDIG-digit BCD to 7-segment driver.
// Latches {d, dp} on load and scans one digit every DIV cycles onto a
// shared segment bus with a one-hot digit enable.
// Optional feature macro: BCD_MUX_LZB_EN enables leading-zero blanking.
module bcd_mux_display
    import bcd7_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
)(
    input logic               clk,
    input logic               reset,
    bcd_mux_display_if.slave  bus
);

    localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] shadow_d;
    logic [NDIG-1:0]   shadow_dp;
    logic [NDIG-1:0]   lz_mask;
    logic [3:0]        cur_digit;
    seg_t              dec_seg;
    logic              tick;
    logic              last_digit;

    assign tick       = (cnt == CW'(DIV - 1));
    assign last_digit = (idx == IW'(NDIG - 1));
    assign cur_digit  = shadow_d[4*idx +: 4];

    bcd_seg7 u_seg7 (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef BCD_MUX_LZB_EN
    // Walk from the top digit down; a digit above 0 is blanked while all digits from it upward are zero
    always_comb begin : lzb_scan
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (shadow_d[4*i +: 4] == 4'd0);
            if (i != 0) begin
                lz_mask[i] = upper_zero;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Prescaler, digit index, shadow register and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            shadow_d  <= '0;
            shadow_dp <= '0;
            bus.seg   <= SEG_BLANK;
            bus.dpo   <= 1'b0;
            bus.an    <= '0;
            bus.frame <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= last_digit ? '0 : idx + IW'(1);
            end
            if (bus.load) begin
                shadow_d  <= bus.d;
                shadow_dp <= bus.dp;
            end
            bus.seg   <= lz_mask[idx] ? SEG_BLANK : dec_seg;
            bus.dpo   <= shadow_dp[idx];
            bus.an    <= NDIG'(1) << idx;
            bus.frame <= tick && last_digit;
        end
    end

endmodule

// File: tb/tb_bcd_mux_display.sv
// tb_bcd_mux_display: randomized self-checking bench for bcd_mux_display
// (NDIG=4, DIV=4). The reference model tracks the number of cycles since
// reset and derives the selected digit and frame pulse arithmetically.
module tb_bcd_mux_display;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    int          m_t;
    logic [15:0] m_d;
    logic [3:0]  m_dp;

    always #5 clk = ~clk;

    bcd_mux_display_if #(.NDIG(NDIG)) bus ();

    bcd_mux_display #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] segOf(input int v);
        case (v)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] refSeg(input int pos);
        int v;
        v = int'((m_d >> (4 * pos)) & 16'hF);
`ifdef BCD_MUX_LZB_EN
        if (pos >= 1 && (m_d >> (4 * pos)) == 16'd0) return 7'b0000000;
`endif
        return segOf(v);
    endfunction

    function automatic int curPos();
        return (m_t / DIV) % NDIG;
    endfunction

    // One clock cycle: drive inputs, predict outputs, advance model, compare
    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] dv, input logic [3:0] dpv);
        int         pos;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dpo;
        logic       e_frame;
        reset    = rst;
        bus.load = ld;
        bus.d    = dv;
        bus.dp   = dpv;
        if (rst) begin
            e_seg = '0; e_an = '0; e_dpo = 1'b0; e_frame = 1'b0;
            m_t = 0; m_d = '0; m_dp = '0;
        end else begin
            pos     = curPos();
            e_seg   = refSeg(pos);
            e_an    = 4'(1 << pos);
            e_dpo   = m_dp[pos];
            e_frame = ((m_t % FRAME) == FRAME - 1);
            m_t++;
            if (ld) begin
                m_d  = dv;
                m_dp = dpv;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("seg",   32'(bus.seg),   32'(e_seg));
        checkOutput("an",    32'(bus.an),    32'(e_an));
        checkOutput("dpo",   32'(bus.dpo),   32'(e_dpo));
        checkOutput("frame", 32'(bus.frame), 32'(e_frame));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom));
        end
    endtask

    function automatic logic [15:0] randDigits();
        logic [15:0] v;
        int          r;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 7));
            if (r <= 4)      v[4*i +: 4] = 4'($urandom_range(0, 9));
            else if (r == 5) v[4*i +: 4] = 4'd0;
            else             v[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.d    = '0;
        bus.dp   = '0;

        // reset held, then release
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h1234, 4'hF);
        idle(6);

        // scan through 4321 with dp on digit 2
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b0100);
        idle(2 * FRAME);

        // load during display of digit 0
        applyStimulus(1'b0, 1'b1, 16'h0005, 4'b0000);
        for (int i = 0; i < FRAME && !(curPos() == 0 && (m_t % DIV) == 0); i++) idle(1);
        idle(1);
        applyStimulus(1'b0, 1'b1, 16'h0009, 4'b0001);
        idle(FRAME);

        // invalid codes
        applyStimulus(1'b0, 1'b1, 16'hFA98, 4'b1010);
        idle(FRAME + 2);

        // leading zeros, all zero
        applyStimulus(1'b0, 1'b1, 16'h0070, 4'b0000);
        idle(FRAME + 2);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b1111);
        idle(FRAME + 2);

        // load coinciding with tick
        for (int i = 0; i < DIV && (m_t % DIV) != DIV - 1; i++) idle(1);
        applyStimulus(1'b0, 1'b1, 16'h8642, 4'b0011);
        idle(FRAME);

        // reset mid-scan while digit 2 is shown
        for (int i = 0; i < FRAME && curPos() != 2; i++) idle(1);
        idle(1);
        applyStimulus(1'b1, 1'b1, 16'h9999, 4'hF);
        idle(FRAME);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0),
                          randDigits(), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
